lin_mul_add: RTL and testbench

LIN_MUL_ADD -- requirements
Module: lin_mul_add

---
 rtl/lin_mul_add_if.sv | 20 ++
 rtl/lin_mul_add.sv | 159 +++++++++++++++
 tb/tb_lin_mul_add.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lin_mul_add_if.sv
// AXI4-Stream bundle shared by the lin_mul_add input and output ports.
// d = sink side (receives data, drives TREADY), s = source side.
interface axi4_stream_if #(
  parameter int DN = 1,
  parameter int DW = 8
) (
  input logic ACLK,
  input logic ARESETn
);
  logic [DN*DW-1:0] TDATA;
  logic [DN-1:0]    TKEEP;
  logic             TLAST;
  logic             TVALID;
  logic             TREADY;

  modport d (input ACLK, input ARESETn, input TDATA, input TKEEP, input TLAST,
             input TVALID, output TREADY);
  modport s (input ACLK, input ARESETn, output TDATA, output TKEEP, output TLAST,
             output TVALID, input TREADY);
endinterface

// File: rtl/lin_mul_add.sv
// Per-lane y = sat/wrap(((x*gain + rnd) >>> SHIFT) + offset) on an AXI4-Stream,
// three elastic register stages, plus a saturating count of clipped beats.
module lin_mul_add #(
  parameter int  DN    = 1,
  parameter type DTI   = logic signed [8-1:0],
  parameter type DTO   = logic signed [8-1:0],
  parameter type DTM   = logic signed [8-1:0],
  parameter type DTS   = DTO,
  parameter int  SHIFT = 6,
  parameter int  CW    = 16
) (
  axi4_stream_if.d        sti,
  axi4_stream_if.s        sto,
  input  DTM              cfg_mul,
  input  DTS              cfg_sum,
  input  logic            cfg_rnd,
  input  logic            cfg_sat,
  input  logic            ctl_clr,
  output logic [CW-1:0]   sts_cnt
);
  localparam int DWI = $bits(DTI);
  localparam int DWO = $bits(DTO);
  localparam int DWM = $bits(DTM);
  localparam int DWS = $bits(DTS);
  localparam int DWP = DWI + DWM;
  localparam int DWR = DWP + 1;
  localparam int WS  = (((DWP - SHIFT) > DWS) ? (DWP - SHIFT) : DWS) + 1;

  localparam logic signed [DWR-1:0] RND_HALF = DWR'(2 ** (SHIFT - 1));
  localparam logic signed [WS-1:0]  O_MAX    = WS'(2 ** (DWO - 1) - 1);
  localparam logic signed [WS-1:0]  O_MIN    = WS'(-(2 ** (DWO - 1)));

  logic w_clk;
  logic w_rst_n;
  assign w_clk   = sti.ACLK;
  assign w_rst_n = sti.ARESETn;

  // Elastic handshake: a stage accepts when empty or when its contents move on.
  logic r_v1, r_v2, r_v3;
  logic w_rdy1, w_rdy2, w_rdy3;
  logic w_ld1, w_ld2, w_ld3;

  assign w_rdy3     = sto.TREADY | ~r_v3;
  assign w_rdy2     = w_rdy3 | ~r_v2;
  assign w_rdy1     = w_rdy2 | ~r_v1;
  assign w_ld1      = sti.TVALID & w_rdy1;
  assign w_ld2      = r_v1 & w_rdy2;
  assign w_ld3      = r_v2 & w_rdy3;
  assign sti.TREADY = w_rdy1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_rdy1) r_v1 <= sti.TVALID;
      if (w_rdy2) r_v2 <= r_v1;
      if (w_rdy3) r_v3 <= r_v2;
    end
  end

  // S1: product, with the rounding choice captured alongside the beat.
  logic signed [DWI-1:0] w_x     [DN];
  logic signed [DWP-1:0] r_p     [DN];
  logic                  r_rnd1;
  logic [DN-1:0]         r_keep1, r_keep2, r_keep3;
  logic                  r_last1, r_last2, r_last3;

  always_comb begin
    for (int l = 0; l < DN; l++) w_x[l] = sti.TDATA[l*DWI +: DWI];
  end

  // NOTE: data/sideband registers carry no reset; the valid flags alone qualify them.
  always_ff @(posedge w_clk) begin
    if (w_ld1) begin
      for (int l = 0; l < DN; l++) r_p[l] <= DWP'(w_x[l]) * DWP'(cfg_mul);
      r_rnd1  <= cfg_rnd;
      r_keep1 <= sti.TKEEP;
      r_last1 <= sti.TLAST;
    end
  end

  // S2: optional half-LSB add, arithmetic shift, offset; WS bits cannot overflow.
  logic signed [DWR-1:0] w_pr [DN];
  logic signed [WS-1:0]  w_s  [DN];
  logic signed [WS-1:0]  r_s  [DN];

  always_comb begin
    for (int l = 0; l < DN; l++) begin
      w_pr[l] = DWR'(r_p[l]) + (r_rnd1 ? RND_HALF : DWR'(0));
      w_s[l]  = WS'(w_pr[l] >>> SHIFT) + WS'(cfg_sum);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_ld2) begin
      for (int l = 0; l < DN; l++) r_s[l] <= w_s[l];
      r_keep2 <= r_keep1;
      r_last2 <= r_last1;
    end
  end

  // S3: clip or wrap; only kept lanes under saturation flag the beat as clipped.
  logic [DWO-1:0] w_o   [DN];
  logic [DWO-1:0] r_o   [DN];
  logic [DN-1:0]  w_clip;

  // NOTE: defaults first in every combinational block so no path leaves a latch.
  always_comb begin
    w_clip = '0;
    for (int l = 0; l < DN; l++) begin
      w_o[l] = r_s[l][DWO-1:0];
      if (cfg_sat) begin
        if (r_s[l] > O_MAX) begin
          w_o[l]    = O_MAX[DWO-1:0];
          w_clip[l] = r_keep2[l];
        end else if (r_s[l] < O_MIN) begin
          w_o[l]    = O_MIN[DWO-1:0];
          w_clip[l] = r_keep2[l];
        end
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_ld3) begin
      for (int l = 0; l < DN; l++) r_o[l] <= w_o[l];
      r_keep3 <= r_keep2;
      r_last3 <= r_last2;
    end
  end

  logic [DN*DWO-1:0] w_tdata;
  always_comb begin
    w_tdata = '0;
    for (int l = 0; l < DN; l++) w_tdata[l*DWO +: DWO] = r_o[l];
  end

  assign sto.TDATA  = w_tdata;
  assign sto.TKEEP  = r_keep3;
  assign sto.TLAST  = r_last3;
  assign sto.TVALID = r_v3;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  logic [CW-1:0] r_cnt;
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt <= '0;
    end else if (ctl_clr) begin
      r_cnt <= '0;
    end else if (w_ld3 && (|w_clip) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sts_cnt = r_cnt;
endmodule

// File: tb/tb_lin_mul_add.sv
// Directed bench for lin_mul_add: vector table for arithmetic, then sequences
// for backpressure, counter saturation/clear and asynchronous reset.
module tb_lin_mul_add;
  logic clk;
  logic rst_n;

  axi4_stream_if #(.DN(1), .DW(8)) sti_if (.ACLK(clk), .ARESETn(rst_n));
  axi4_stream_if #(.DN(1), .DW(8)) sto_if (.ACLK(clk), .ARESETn(rst_n));

  logic signed [7:0] cfg_mul;
  logic signed [7:0] cfg_sum;
  logic              cfg_rnd;
  logic              cfg_sat;
  logic              ctl_clr;
  logic [3:0]        sts_cnt;

  lin_mul_add #(.CW(4)) dut (
    .sti     (sti_if),
    .sto     (sto_if),
    .cfg_mul (cfg_mul),
    .cfg_sum (cfg_sum),
    .cfg_rnd (cfg_rnd),
    .cfg_sat (cfg_sat),
    .ctl_clr (ctl_clr),
    .sts_cnt (sts_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic signed [7:0] x;
    logic signed [7:0] mul;
    logic signed [7:0] sum;
    logic              rnd;
    logic              sat;
    logic              keep;
    logic              last;
    logic [7:0]        eo;
    logic              clip;
  } vec_t;

  function automatic vec_t mk(int x, int mul, int sum, bit rnd, bit sat, bit keep,
                              bit last, int eo, bit clip);
    vec_t v;
    v.x = 8'(x); v.mul = 8'(mul); v.sum = 8'(sum);
    v.rnd = rnd; v.sat = sat; v.keep = keep; v.last = last;
    v.eo = 8'(eo); v.clip = clip;
    return v;
  endfunction

  vec_t vt[15];
  int   exp_cnt;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    sti_if.TDATA  = '0;
    sti_if.TKEEP  = '0;
    sti_if.TLAST  = 1'b0;
    sti_if.TVALID = 1'b0;
    sto_if.TREADY = 1'b1;
    cfg_mul = 8'sd64; cfg_sum = 8'sd0; cfg_rnd = 1'b0; cfg_sat = 1'b1; ctl_clr = 1'b0;

    vt[0]  = mk(  37,   64,   0, 0, 1, 1, 0,   37, 0);
    vt[1]  = mk( 100,  127,   0, 0, 1, 1, 1,  127, 1);
    vt[2]  = mk( 100,  127,   0, 0, 0, 1, 0,  -58, 0);
    vt[3]  = mk(-100,  127,   0, 0, 1, 1, 0, -128, 1);
    vt[4]  = mk(   3,   32,   0, 0, 1, 1, 1,    1, 0);
    vt[5]  = mk(   3,   32,   0, 1, 1, 1, 0,    2, 0);
    vt[6]  = mk(  -3,   32,   0, 0, 1, 1, 0,   -2, 0);
    vt[7]  = mk(  -3,   32,   0, 1, 1, 1, 1,   -1, 0);
    vt[8]  = mk(   3,   32,  -5, 0, 1, 1, 0,   -4, 0);
    vt[9]  = mk(-128, -128,   0, 0, 1, 1, 0,  127, 1);
    vt[10] = mk(-128, -128,   0, 0, 0, 1, 0,    0, 0);
    vt[11] = mk(  50,   64, 100, 0, 1, 1, 0,  127, 1);
    vt[12] = mk( -64,   64, -64, 0, 1, 1, 0, -128, 0);
    vt[13] = mk( 127,   64,   0, 0, 1, 1, 0,  127, 0);
    vt[14] = mk( 100,  127,   0, 0, 1, 0, 1,  127, 0);

    // Reset state.
    step();
    step();
    check("rst_tvalid", int'(sto_if.TVALID), 0);
    check("rst_cnt",    int'(sts_cnt),       0);
    check("rst_tready", int'(sti_if.TREADY), 1);
    rst_n = 1'b1;
    step();

    // Single beats through an idle pipeline.
    exp_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cfg_mul = vt[i].mul; cfg_sum = vt[i].sum; cfg_rnd = vt[i].rnd; cfg_sat = vt[i].sat;
      sti_if.TDATA  = vt[i].x;
      sti_if.TKEEP  = vt[i].keep;
      sti_if.TLAST  = vt[i].last;
      sti_if.TVALID = 1'b1;
      step();
      sti_if.TVALID = 1'b0;
      step();
      check($sformatf("v%0d_early", i), int'(sto_if.TVALID), 0);
      step();
      exp_cnt += int'(vt[i].clip);
      check($sformatf("v%0d_valid", i), int'(sto_if.TVALID), 1);
      check($sformatf("v%0d_data", i),  int'(sto_if.TDATA),  int'(vt[i].eo));
      check($sformatf("v%0d_keep", i),  int'(sto_if.TKEEP),  int'(vt[i].keep));
      check($sformatf("v%0d_last", i),  int'(sto_if.TLAST),  int'(vt[i].last));
      check($sformatf("v%0d_cnt", i),   int'(sts_cnt),       exp_cnt);
      step();
    end

    // Backpressure: 10 beats, sink stalled for cycles 4..8.
    begin
      int in_idx = 0, out_idx = 0, inflight = 0;
      bit saw_stall = 0;
      bit fin, fout;
      cfg_mul = 8'sd64; cfg_sum = 8'sd0; cfg_rnd = 1'b0; cfg_sat = 1'b1;
      sti_if.TKEEP = 1'b1;
      for (int c = 0; c < 40; c++) begin
        sto_if.TREADY = !(c >= 4 && c <= 8);
        if (in_idx < 10) begin
          sti_if.TDATA  = 8'(10 * in_idx + 3);
          sti_if.TLAST  = (in_idx == 9);
          sti_if.TVALID = 1'b1;
        end else begin
          sti_if.TVALID = 1'b0;
          sti_if.TLAST  = 1'b0;
        end
        @(negedge clk);
        check($sformatf("bp_c%0d_tready", c), int'(sti_if.TREADY),
              int'(!(inflight == 3 && !sto_if.TREADY)));
        if (!sti_if.TREADY) saw_stall = 1;
        fin  = sti_if.TVALID && sti_if.TREADY;
        fout = sto_if.TVALID && sto_if.TREADY;
        if (fout) begin
          check($sformatf("bp_o%0d_data", out_idx), int'(sto_if.TDATA), 10 * out_idx + 3);
          check($sformatf("bp_o%0d_last", out_idx), int'(sto_if.TLAST), int'(out_idx == 9));
          out_idx++;
        end
        if (fin) in_idx++;
        inflight += int'(fin) - int'(fout);
        step();
      end
      check("bp_stall_seen", int'(saw_stall), 1);
      check("bp_in_count",   in_idx,  10);
      check("bp_out_count",  out_idx, 10);
      sto_if.TREADY = 1'b1;
    end

    // Counter: clear, saturate at 15, then clear coincident with a clipped S3 entry.
    ctl_clr = 1'b1;
    step();
    ctl_clr = 1'b0;
    check("clr_cnt", int'(sts_cnt), 0);
    cfg_mul = 8'sd127; cfg_sat = 1'b1;
    sti_if.TDATA = 8'sd100; sti_if.TKEEP = 1'b1; sti_if.TLAST = 1'b0;
    sti_if.TVALID = 1'b1;
    repeat (20) step();
    sti_if.TVALID = 1'b0;
    repeat (4) step();
    check("sat_cnt", int'(sts_cnt), 15);
    sti_if.TVALID = 1'b1;
    step();
    sti_if.TVALID = 1'b0;
    step();
    ctl_clr = 1'b1;
    step();
    ctl_clr = 1'b0;
    check("clr_prio_cnt",   int'(sts_cnt),       0);
    check("clr_prio_valid", int'(sto_if.TVALID), 1);
    check("clr_prio_data",  int'(sto_if.TDATA),  127);
    step();

    // Asynchronous reset with three clipped beats in flight.
    sti_if.TVALID = 1'b1;
    repeat (3) step();
    sti_if.TVALID = 1'b0;
    check("ar_pre_valid", int'(sto_if.TVALID), 1);
    check("ar_pre_cnt",   int'(sts_cnt),       1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", int'(sto_if.TVALID), 0);
    check("ar_cnt",   int'(sts_cnt),       0);
    check("ar_ready", int'(sti_if.TREADY), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    check("ar_flushed", int'(sto_if.TVALID), 0);
    cfg_mul = 8'sd64; cfg_sum = 8'sd0;
    sti_if.TDATA = 8'sd37;
    sti_if.TVALID = 1'b1;
    step();
    sti_if.TVALID = 1'b0;
    step();
    check("ar_new_early", int'(sto_if.TVALID), 0);
    step();
    check("ar_new_valid", int'(sto_if.TVALID), 1);
    check("ar_new_data",  int'(sto_if.TDATA),  37);
    check("ar_new_cnt",   int'(sts_cnt),       0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
